rsa_decryption: RTL and testbench

RSA decryption engine, paired with the upstream encryption block.
- Waits for the encryptor's done strobe, then derives the private key d = e^-1 mod phi.
- Recovers plaintext as d_data = (e_data mod n)^d mod n.
- Outputs feed downstream checking/consumer logic. Pure sequential block with one clock.

---
 rtl/rsa_decryption.sv | 198 +++++++++++++++++++
 tb/tb_rsa_decryption.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rsa_decryption.sv
// ---------------------------------------------------------------------------
// rsa_decryption
//   Receives a public key, modulus, totient and ciphertext from the upstream
//   encryptor. It derives the private exponent d = e^-1 mod phi by walking
//   the multiples of e. It then recovers the plaintext as
//   (e_data mod n)^d mod n with right-to-left square-and-multiply.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for enc_done; captures inputs on the first edge it is high
//   KEYGEN | one candidate d per cycle, residue r = d*e mod phi tracked
//   EXP    | one exponent bit per cycle: multiply when the bit is set, square base
//   DONE   | done_d high, results held; leaves when enc_done drops
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   e_key    : public exponent e
//   e_data   : ciphertext
//   phival   : totient (p-1)(q-1)
//   nval     : modulus p*q
//   enc_done : level, inputs valid while high
//   d_key    : private exponent d (0 when no inverse or inputs invalid)
//   d_data   : decrypted plaintext
//   done_d   : results valid
// ---------------------------------------------------------------------------
module rsa_decryption #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] e_key,
    input  logic [WIDTH-1:0] e_data,
    input  logic [WIDTH-1:0] phival,
    input  logic [WIDTH-1:0] nval,
    input  logic             enc_done,
    output logic [WIDTH-1:0] d_key,
    output logic [WIDTH-1:0] d_data,
    output logic             done_d
);

    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYGEN = 2'd1,
        EXP    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] emod_q, emod_d;      // e mod phi, the per-step residue increment
    logic [WIDTH-1:0] phi_q, phi_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] cand_q, cand_d;      // candidate d
    logic [WIDTH-1:0] r_q, r_d;            // cand * e mod phi
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] d_key_q, d_key_d;
    logic [WIDTH-1:0] d_data_q, d_data_d;
    logic             done_q, done_d_nxt;

    // Divisors forced nonzero so the mod operators never see zero; the
    // affected results are only used after validation has ruled zero out.
    logic [WIDTH-1:0] cap_n_div, cap_phi_div;
    logic [WIDTH-1:0] cap_data_mod, cap_e_mod;
    logic             cap_invalid;
    logic [W2-1:0]    n_div_w;
    logic [W2-1:0]    prod_rb, prod_bb;
    logic [W2-1:0]    mod_rb, mod_bb;
    logic [WIDTH:0]   r_sum;
    logic [WIDTH-1:0] r_next;

    always_comb begin
        cap_n_div    = (nval == '0) ? WIDTH'(1) : nval;
        cap_phi_div  = (phival == '0) ? WIDTH'(1) : phival;
        cap_data_mod = e_data % cap_n_div;
        cap_e_mod    = e_key % cap_phi_div;
        cap_invalid  = (phival < WIDTH'(2)) || (nval == '0) || (e_key == '0);

        n_div_w = (n_q == '0) ? W2'(1) : {{WIDTH{1'b0}}, n_q};
        prod_rb = {{WIDTH{1'b0}}, result_q} * {{WIDTH{1'b0}}, base_q};
        prod_bb = {{WIDTH{1'b0}}, base_q} * {{WIDTH{1'b0}}, base_q};
        mod_rb  = prod_rb % n_div_w;
        mod_bb  = prod_bb % n_div_w;

        // Both operands are below phi, so one conditional subtraction reduces the sum.
        r_sum  = {1'b0, r_q} + {1'b0, emod_q};
        r_next = (r_sum >= {1'b0, phi_q}) ? WIDTH'(r_sum - {1'b0, phi_q}) : r_sum[WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        emod_d     = emod_q;
        phi_d      = phi_q;
        n_d        = n_q;
        cand_d     = cand_q;
        r_d        = r_q;
        exp_d      = exp_q;
        base_d     = base_q;
        result_d   = result_q;
        d_key_d    = d_key_q;
        d_data_d   = d_data_q;
        done_d_nxt = done_q;

        unique case (state_q)
            IDLE: begin
                if (enc_done) begin
                    phi_d  = phival;
                    n_d    = nval;
                    emod_d = cap_e_mod;
                    r_d    = cap_e_mod;
                    base_d = cap_data_mod;
                    cand_d = WIDTH'(1);
                    if (cap_invalid) begin
                        d_key_d    = '0;
                        d_data_d   = '0;
                        done_d_nxt = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = KEYGEN;
                    end
                end
            end
            KEYGEN: begin
                if (r_q == WIDTH'(1)) begin
                    d_key_d  = cand_q;
                    exp_d    = cand_q;
                    result_d = (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    state_d  = EXP;
                end else if (cand_q == phi_q - WIDTH'(1)) begin
                    // gcd(e, phi) != 1: no inverse exists
                    d_key_d    = '0;
                    d_data_d   = '0;
                    done_d_nxt = 1'b1;
                    state_d    = DONE;
                end else begin
                    cand_d = cand_q + WIDTH'(1);
                    r_d    = r_next;
                end
            end
            EXP: begin
                if (exp_q == '0) begin
                    d_data_d   = result_q;
                    done_d_nxt = 1'b1;
                    state_d    = DONE;
                end else begin
                    if (exp_q[0]) result_d = mod_rb[WIDTH-1:0];
                    base_d = mod_bb[WIDTH-1:0];
                    exp_d  = exp_q >> 1;
                end
            end
            DONE: begin
                if (!enc_done) begin
                    done_d_nxt = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            emod_q   <= '0;
            phi_q    <= '0;
            n_q      <= '0;
            cand_q   <= '0;
            r_q      <= '0;
            exp_q    <= '0;
            base_q   <= '0;
            result_q <= '0;
            d_key_q  <= '0;
            d_data_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            emod_q   <= emod_d;
            phi_q    <= phi_d;
            n_q      <= n_d;
            cand_q   <= cand_d;
            r_q      <= r_d;
            exp_q    <= exp_d;
            base_q   <= base_d;
            result_q <= result_d;
            d_key_q  <= d_key_d;
            d_data_q <= d_data_d;
            done_q   <= done_d_nxt;
        end
    end

    assign d_key  = d_key_q;
    assign d_data = d_data_q;
    assign done_d = done_q;

endmodule

// File: tb/tb_rsa_decryption.sv
module tb_rsa_decryption;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] e_key;
    logic [WIDTH-1:0] e_data;
    logic [WIDTH-1:0] phival;
    logic [WIDTH-1:0] nval;
    logic             enc_done;
    logic [WIDTH-1:0] d_key;
    logic [WIDTH-1:0] d_data;
    logic             done_d;

    int tests = 0;
    int fails = 0;

    rsa_decryption #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .e_key    (e_key),
        .e_data   (e_data),
        .phival   (phival),
        .nval     (nval),
        .enc_done (enc_done),
        .d_key    (d_key),
        .d_data   (d_data),
        .done_d   (done_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Wait for done_d, at most 'bound' rising edges, sampling 1 time unit after each edge.
    task automatic wait_done(input string tag, input int bound);
        int n;
        n = 0;
        while (n < bound && done_d !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done_in_time"}, {31'd0, done_d}, 32'd1);
    endtask

    // Raise enc_done with new operands on a falling edge.
    task automatic start(input logic [WIDTH-1:0] ek, input logic [WIDTH-1:0] ed,
                         input logic [WIDTH-1:0] ph, input logic [WIDTH-1:0] nv);
        @(negedge clk);
        e_key    = ek;
        e_data   = ed;
        phival   = ph;
        nval     = nv;
        enc_done = 1'b1;
    endtask

    // Drop enc_done and let the block settle back in IDLE.
    task automatic release_done();
        @(negedge clk);
        enc_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b0;
        enc_done = 1'b0;
        e_key    = '0;
        e_data   = '0;
        phival   = '0;
        nval     = '0;
        #2;
        check("rst_d_key", d_key, 32'd0);
        check("rst_d_data", d_data, 32'd0);
        check("rst_done", {31'd0, done_d}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Case 1: e=5, phi=6, n=14, c=3 -> d=5, m=3^5 mod 14=5
        start(32'd5, 32'd3, 32'd6, 32'd14);
        wait_done("c1", 6 + WIDTH + 3);
        check("c1_d_key", d_key, 32'd5);
        check("c1_d_data", d_data, 32'd5);
        repeat (3) @(posedge clk);
        #1;
        check("c1_done_held", {31'd0, done_d}, 32'd1);

        // Handshake: done_d falls on the first edge after enc_done drops
        @(negedge clk);
        enc_done = 1'b0;
        @(posedge clk);
        #1;
        check("hs_done_fall", {31'd0, done_d}, 32'd0);
        check("hs_d_key_kept", d_key, 32'd5);
        check("hs_d_data_kept", d_data, 32'd5);
        repeat (2) @(negedge clk);

        // Case 2: ciphertext above n is reduced first (17 mod 14 = 3)
        start(32'd5, 32'd17, 32'd6, 32'd14);
        wait_done("c2a", 6 + WIDTH + 3);
        check("c2a_d_key", d_key, 32'd5);
        check("c2a_d_data", d_data, 32'd5);
        release_done();
        // 5^5 = 3125 = 223*14 + 3
        start(32'd5, 32'd5, 32'd6, 32'd14);
        wait_done("c2b", 6 + WIDTH + 3);
        check("c2b_d_data", d_data, 32'd3);
        release_done();

        // Case 3: e=7, phi=60, n=77, c=2 -> d=43, 2^43 mod 77 = 30
        start(32'd7, 32'd2, 32'd60, 32'd77);
        wait_done("c3", 60 + WIDTH + 3);
        check("c3_d_key", d_key, 32'd43);
        check("c3_d_data", d_data, 32'd30);
        release_done();

        // Case 4: no inverse, e=0, phi=1 all give zeros
        start(32'd4, 32'd3, 32'd6, 32'd14);
        wait_done("c4a", 6 + WIDTH + 3);
        check("c4a_d_key", d_key, 32'd0);
        check("c4a_d_data", d_data, 32'd0);
        release_done();
        start(32'd5, 32'd3, 32'd6, 32'd14);
        wait_done("c4_prime", 6 + WIDTH + 3);
        release_done();
        start(32'd0, 32'd3, 32'd6, 32'd14);
        wait_done("c4b", 6 + WIDTH + 3);
        check("c4b_d_key", d_key, 32'd0);
        check("c4b_d_data", d_data, 32'd0);
        release_done();
        start(32'd5, 32'd3, 32'd6, 32'd14);
        wait_done("c4_prime2", 6 + WIDTH + 3);
        release_done();
        start(32'd5, 32'd3, 32'd1, 32'd14);
        wait_done("c4c", 1 + WIDTH + 3);
        check("c4c_d_key", d_key, 32'd0);
        check("c4c_d_data", d_data, 32'd0);
        release_done();

        // Case 5: new run with plaintext 1
        start(32'd5, 32'd1, 32'd6, 32'd14);
        wait_done("c5", 6 + WIDTH + 3);
        check("c5_d_key", d_key, 32'd5);
        check("c5_d_data", d_data, 32'd1);
        release_done();

        // Case 6: reset mid-EXP of the phi=60 run (KEYGEN ends 43 edges after capture)
        start(32'd7, 32'd2, 32'd60, 32'd77);
        @(posedge clk);
        repeat (45) @(posedge clk);
        #1;
        check("c6_pre_done", {31'd0, done_d}, 32'd0);
        check("c6_pre_d_key", d_key, 32'd43);
        #2;
        rst = 1'b0;
        #1;
        check("c6_rst_d_key", d_key, 32'd0);
        check("c6_rst_d_data", d_data, 32'd0);
        check("c6_rst_done", {31'd0, done_d}, 32'd0);
        e_key  = 32'd5;
        e_data = 32'd3;
        phival = 32'd6;
        nval   = 32'd14;
        @(negedge clk);
        rst = 1'b1;
        wait_done("c6_rerun", 6 + WIDTH + 4);
        check("c6_d_key", d_key, 32'd5);
        check("c6_d_data", d_data, 32'd5);
        release_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
